// File: rtl/coin_acc_pkg.sv
// Shared types and default thresholds for the coin acceptor.
// The JAM state exists only when COIN_ACC_JAM_DETECT_EN is defined.
package coin_acc_pkg;

  localparam int W_CNT_W = 8;

  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_HALF_MIN   = 10;
  localparam int DEF_HALF_MAX   = 29;
  localparam int DEF_ONE_MIN    = 30;
  localparam int DEF_ONE_MAX    = 60;
  localparam int DEF_GAP_CYCLES = 16;
  localparam int DEF_JAM_CYCLES = 200;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MEASURE  = 3'd1,
    S_EMIT     = 3'd2,
`ifdef COIN_ACC_JAM_DETECT_EN
    S_COOLDOWN = 3'd3,
    S_JAM      = 3'd4
`else
    S_COOLDOWN = 3'd3
`endif
  } coin_state_e;

  function automatic logic [W_CNT_W-1:0] sat_inc(input logic [W_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// Two-flop synchronizer plus debounce filter for the coin sensor.
// rise/fall strobe in the cycle before the filtered level changes.
module coin_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic raw,
  output logic filtered,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] stable_cnt;
  logic             differ;
  logic             commit;

  assign differ = (sync_2 != filtered);
  assign commit = differ && (stable_cnt == CNT_W'(DEB_CYCLES - 1));
  assign rise   = commit && sync_2;
  assign fall   = commit && !sync_2;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      filtered   <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      // Any agreement with the current level restarts the stability window.
      if (!differ) begin
        stable_cnt <= '0;
      end else if (commit) begin
        stable_cnt <= '0;
        filtered   <= sync_2;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: measures the debounced sensor high width and pulses half/one/reject.
// Optional jam detection is compiled in with COIN_ACC_JAM_DETECT_EN.
module coin_acceptor
  import coin_acc_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int HALF_MIN   = DEF_HALF_MIN,
  parameter int HALF_MAX   = DEF_HALF_MAX,
  parameter int ONE_MIN    = DEF_ONE_MIN,
  parameter int ONE_MAX    = DEF_ONE_MAX,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int JAM_CYCLES = DEF_JAM_CYCLES
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic pi_coin_sense,
  output logic po_money_one,
  output logic po_money_half,
  output logic po_reject,
  output logic po_jam
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic               filtered;
  logic               rise;
  logic               fall;
  coin_state_e        state;
  coin_state_e        state_n;
  logic [W_CNT_W-1:0] width;
  logic [W_CNT_W-1:0] width_n;
  logic [GAP_W-1:0]   gap;
  logic [GAP_W-1:0]   gap_n;
  logic               w_half;
  logic               w_one;
  logic               emit;

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .raw       (pi_coin_sense),
    .filtered  (filtered),
    .rise      (rise),
    .fall      (fall)
  );

  assign w_half = (int'(width) >= HALF_MIN) && (int'(width) <= HALF_MAX);
  assign w_one  = (int'(width) >= ONE_MIN) && (int'(width) <= ONE_MAX);
  assign emit   = (state == S_EMIT);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;
      width <= '0;
      gap   <= '0;
    end else begin
      state <= state_n;
      width <= width_n;
      gap   <= gap_n;
    end
  end

  always_comb begin
    state_n = state;
    width_n = width;
    gap_n   = gap;
    case (state)
      S_IDLE: begin
        if (rise) begin
          state_n = S_MEASURE;
          width_n = '0;
        end
      end
      S_MEASURE: begin
        // The fall strobe arrives in the last high cycle, so that cycle is counted too.
        if (filtered) width_n = sat_inc(width);
        if (fall) begin
          state_n = S_EMIT;
`ifdef COIN_ACC_JAM_DETECT_EN
        end else if (width_n == W_CNT_W'(JAM_CYCLES)) begin
          state_n = S_JAM;
`endif
        end
      end
      S_EMIT: begin
        state_n = S_COOLDOWN;
        gap_n   = '0;
      end
      S_COOLDOWN: begin
        if (gap == GAP_W'(GAP_CYCLES - 1)) state_n = S_IDLE;
        else gap_n = gap + 1'b1;
      end
`ifdef COIN_ACC_JAM_DETECT_EN
      S_JAM: begin
        if (fall) begin
          state_n = S_COOLDOWN;
          gap_n   = '0;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      po_money_one  <= 1'b0;
      po_money_half <= 1'b0;
      po_reject     <= 1'b0;
    end else begin
      po_money_half <= emit && w_half;
      po_money_one  <= emit && !w_half && w_one;
      po_reject     <= emit && !w_half && !w_one;
    end
  end

`ifdef COIN_ACC_JAM_DETECT_EN
  assign po_jam = (state == S_JAM);
`else
  logic unused_jam_cycles;
  assign unused_jam_cycles = (JAM_CYCLES < 0);
  assign po_jam = 1'b0;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Randomized and directed bench for coin_acceptor against a width-based reference model.
// Honours COIN_ACC_JAM_DETECT_EN the same way as the design.
module tb_coin_acceptor;

  localparam int HALF_MIN = 10;
  localparam int HALF_MAX = 29;
  localparam int ONE_MIN  = 30;
  localparam int ONE_MAX  = 60;
  localparam int GAP      = 16;
  localparam int JAM      = 200;
  localparam int DEB      = 4;
  localparam int LATENCY  = 2 + DEB + 1;

  logic sys_clk;
  logic sys_rst_n;
  logic pi_coin_sense;
  logic po_money_one;
  logic po_money_half;
  logic po_reject;
  logic po_jam;

  int n_checks;
  int n_fail;
  int cyc;
  int idle_from;
  int jam_lo;
  int jam_hi;

  // Scoreboard: expected pulse kind {one, half, reject} and the cycle it must appear in.
  logic [2:0] exp_q[$];
  int         exp_t_q[$];

  coin_acceptor dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .pi_coin_sense (pi_coin_sense),
    .po_money_one  (po_money_one),
    .po_money_half (po_money_half),
    .po_reject     (po_reject),
    .po_jam        (po_jam)
  );

  // Clock and cycle counter
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [2:0] classify(input int w);
    if (w >= HALF_MIN && w <= HALF_MAX) return 3'b010;
    if (w >= ONE_MIN && w <= ONE_MAX) return 3'b100;
    return 3'b001;
  endfunction

  // Reference model: decide the outcome of one raw pulse from its width and start time.
  task automatic model_coin(input int c, input int f);
    int w;
    w = f - c;
    // A pulse shorter than DEB never reaches the filtered level; one whose
    // filtered rise lands before the FSM is idle again is ignored.
    if (w < DEB || c + DEB + 1 < idle_from) return;
`ifdef COIN_ACC_JAM_DETECT_EN
    if (w > JAM) begin
      jam_lo    = c + DEB + 2 + JAM;
      jam_hi    = f + DEB + 1;
      idle_from = f + DEB + 2 + GAP;
      return;
    end
`endif
    exp_q.push_back(classify(w));
    exp_t_q.push_back(f + LATENCY);
    idle_from = f + LATENCY + GAP;
  endtask

  // Driver: raw high for 'width' cycles, then low for 'gap' cycles.
  task automatic coin(input int width, input int gap);
    int c;
    int f;
    @(negedge sys_clk);
    c = cyc;
    pi_coin_sense = 1'b1;
    repeat (width) @(negedge sys_clk);
    f = cyc;
    pi_coin_sense = 1'b0;
    model_coin(c, f);
    repeat (gap) @(negedge sys_clk);
  endtask

  task automatic check_quiet_outputs(input string tag);
    check(tag, 32'({po_money_one, po_money_half, po_reject, po_jam}), 32'd0);
  endtask

  // Monitor: every pulse must match the scoreboard head in kind and cycle.
  always @(negedge sys_clk) begin
    logic [2:0] obs;
    logic [2:0] exp;
    if (sys_rst_n) begin
      obs = {po_money_one, po_money_half, po_reject};
      exp = 3'b000;
      while (exp_t_q.size() > 0 && exp_t_q[0] < cyc) begin
        check("missed_pulse", 32'd0, 32'(exp_q.pop_front()));
        void'(exp_t_q.pop_front());
      end
      if (exp_t_q.size() > 0 && exp_t_q[0] == cyc) begin
        exp = exp_q.pop_front();
        void'(exp_t_q.pop_front());
      end
      if (obs != 3'b000 || exp != 3'b000) check("pulse", 32'(obs), 32'(exp));
      check("jam", 32'(po_jam), 32'(cyc >= jam_lo && cyc <= jam_hi));
    end
  end

  initial begin
    int r;
    int f;
    n_checks      = 0;
    n_fail        = 0;
    idle_from     = 0;
    jam_lo        = 1;
    jam_hi        = 0;
    sys_rst_n     = 1'b0;
    pi_coin_sense = 1'b0;

    repeat (3) @(negedge sys_clk);
    check_quiet_outputs("reset_outputs");
    sys_rst_n = 1'b1;
    idle_from = cyc;
    repeat (5) @(negedge sys_clk);

    // Main classes, short reject, glitch and width boundaries
    coin(20, 30);
    coin(45, 30);
    coin(5, 30);
    coin(2, 30);
    coin(9, 30);
    coin(10, 30);
    coin(29, 30);
    coin(30, 30);
    coin(60, 30);
    coin(61, 30);

    // Second coin 5 cycles after the first pulse is ignored, 20 cycles after is counted
    coin(20, LATENCY + 5);
    coin(20, 40);
    coin(20, LATENCY + 20);
    coin(45, 40);

    // Long coin: jam level with the feature, reject without it
    coin(250, 40);

    // Reset 15 cycles into a 40-cycle coin, held until the coin is gone
    @(negedge sys_clk);
    pi_coin_sense = 1'b1;
    repeat (15) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    exp_q.delete();
    exp_t_q.delete();
    jam_lo = 1;
    jam_hi = 0;
    #1 check_quiet_outputs("reset_async_clear");
    repeat (25) begin
      @(negedge sys_clk);
      check_quiet_outputs("reset_hold");
    end
    pi_coin_sense = 1'b0;
    repeat (10) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle_from = cyc;
    repeat (40) @(negedge sys_clk);

    // Release reset with the sensor already high: measured as a normal 20-cycle coin
    sys_rst_n     = 1'b0;
    pi_coin_sense = 1'b1;
    repeat (3) @(negedge sys_clk);
    r = cyc;
    sys_rst_n = 1'b1;
    idle_from = r;
    repeat (20) @(negedge sys_clk);
    f = cyc;
    pi_coin_sense = 1'b0;
    model_coin(r, f);
    repeat (40) @(negedge sys_clk);

    // Random widths and gaps around the classification and cooldown boundaries
    for (int i = 0; i < 40; i++) begin
      coin($urandom_range(70, 1), $urandom_range(40, 5));
    end

    repeat (40) @(negedge sys_clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 The module SHALL have parameter DEB_CYCLES, default 4, meaning consecutive stable cycles required before the filtered sensor level changes.
REQ-002 The module SHALL have parameter HALF_MIN, default 10, meaning the minimum filtered high width in cycles for a half coin.
REQ-003 The module SHALL have parameter HALF_MAX, default 29, meaning the maximum filtered high width in cycles for a half coin.
REQ-004 The module SHALL have parameter ONE_MIN, default 30, meaning the minimum filtered high width in cycles for a one coin.
REQ-005 The module SHALL have parameter ONE_MAX, default 60, meaning the maximum filtered high width in cycles for a one coin.
REQ-006 The module SHALL have parameter GAP_CYCLES, default 16, meaning the cooldown length in cycles after each coin event.
REQ-007 The module SHALL have parameter JAM_CYCLES, default 200, meaning the filtered high width in cycles that counts as a jam.
REQ-008 The module SHALL have port sys_clk, input, 1 bit: the single clock, rising-edge.
REQ-009 The module SHALL have port sys_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-010 The module SHALL have port pi_coin_sense, input, 1 bit: raw asynchronous coin-slot sensor, high while a coin passes.
REQ-011 The module SHALL have port po_money_one, output, 1 bit: a one-cycle pulse per accepted one coin; it drives the vending machine pi_money_one input.
REQ-012 The module SHALL have port po_money_half, output, 1 bit: a one-cycle pulse per accepted half coin; it drives the vending machine pi_money_half input.
REQ-013 The module SHALL have port po_reject, output, 1 bit: a one-cycle pulse per coin with an out-of-band width.
REQ-014 The module SHALL have port po_jam, output, 1 bit: the jam level.

Function
REQ-015 pi_coin_sense SHALL pass through a 2-flop synchronizer.
REQ-016 The filtered level SHALL take the synchronized value once that value has differed from the filtered level for DEB_CYCLES consecutive cycles; shorter glitches SHALL be ignored.
REQ-017 The FSM SHALL have states IDLE, MEASURE, EMIT, COOLDOWN and, when jam detection is compiled in, JAM.
REQ-018 In IDLE, a filtered rising edge SHALL clear the width counter and move the FSM to MEASURE.
REQ-019 In MEASURE, the width counter SHALL increment once per cycle while the filtered level is high; the 8-bit counter SHALL saturate at 255.
REQ-020 In MEASURE, a filtered falling edge SHALL move the FSM to EMIT with W equal to the counted high cycles.
REQ-021 EMIT SHALL last one cycle; the output pulse SHALL be registered and assert in the cycle after EMIT is entered.
REQ-022 Classification SHALL be: HALF_MIN<=W<=HALF_MAX gives po_money_half; ONE_MIN<=W<=ONE_MAX gives po_money_one; any other W gives po_reject.
REQ-023 Exactly one of po_money_one, po_money_half, po_reject SHALL pulse per coin, each for exactly 1 cycle, and never two of them in the same cycle.
REQ-024 Total latency from a clean raw falling edge to the output pulse SHALL be 2+DEB_CYCLES+1 cycles (7 at the defaults).
REQ-025 COOLDOWN SHALL last GAP_CYCLES cycles, then return to IDLE.
REQ-026 Filtered rising edges during COOLDOWN SHALL be ignored.
REQ-027 If the filtered level is still high when COOLDOWN ends, the FSM SHALL return to IDLE without a new measurement, which requires a fresh rising edge.
REQ-028 A filtered high lasting less than HALF_MIN cycles SHALL produce po_reject.

Reset
REQ-029 Asserting sys_rst_n low SHALL immediately clear all outputs, counters, synchronizer flops and the filtered level to 0, and return the FSM to IDLE.
REQ-030 A reset mid-MEASURE SHALL discard the coin, and no pulse SHALL follow the reset release.
REQ-031 After reset release with pi_coin_sense already high, the first filtered rising edge SHALL be measured normally.

Configuration
REQ-032 When COIN_ACC_JAM_DETECT_EN is defined, reaching W=JAM_CYCLES in MEASURE SHALL move the FSM to JAM with po_jam=1 from the next cycle.
REQ-033 In JAM, the filtered falling edge SHALL clear po_jam and move the FSM to COOLDOWN with no coin or reject pulse.
REQ-034 When COIN_ACC_JAM_DETECT_EN is undefined, the JAM state and its logic SHALL be absent, po_jam SHALL be tied to 0, and long widths SHALL be rejected on the falling edge.

Structure
REQ-035 Package coin_acc_pkg SHALL hold the FSM state encoding, the width-counter width (8), and the default threshold constants.
REQ-036 The synchronizer and debounce logic SHALL be one sub-module, coin_debounce, with ports sys_clk, sys_rst_n, raw in and filtered out, parameterized by DEB_CYCLES.

Verification
REQ-037 A clean raw high of 20 cycles SHALL produce one po_money_half pulse exactly 7 cycles after the raw fall, with po_money_one=0 and po_reject=0.
REQ-038 A clean raw high of 45 cycles SHALL produce one po_money_one pulse of width 1 cycle.
REQ-039 A raw high of 5 cycles SHALL produce po_reject; a 2-cycle glitch SHALL produce no pulse at all.
REQ-040 A second coin starting 5 cycles after the first pulse (inside COOLDOWN) SHALL be ignored; one starting 20 cycles after SHALL be counted.
REQ-041 With COIN_ACC_JAM_DETECT_EN defined, a raw high of 250 cycles SHALL raise po_jam after 200 filtered cycles and clear it on release, with no other pulse; with the macro undefined, the same stimulus SHALL produce po_reject.
REQ-042 Reset asserted 15 cycles into a 40-cycle coin SHALL produce no pulse, and all outputs SHALL be 0 during reset.
